// File: rtl/mem_if_pkg.sv
// Shared line/beat geometry and serializer state encoding for the memory-side interface.
package mem_if_pkg;

  localparam int LINE_W         = 256;
  localparam int BEAT_W         = 64;
  localparam int BEATS_PER_LINE = LINE_W / BEAT_W;
  localparam int WORDS_PER_BEAT = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_BEAT = 3'd1,
    ST_RD_CMD  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/line_assembler.sv
// Collects returned read beats into a holding line and publishes it on commit.
// Zero latency to holding register; published line changes only on commit.
module line_assembler
  import mem_if_pkg::*;
#(
  parameter int BEATS = BEATS_PER_LINE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(BEATS)-1:0] wr_idx,
  input  logic [BEAT_W-1:0]        wr_beat,
  input  logic                     commit,
  output logic [LINE_W-1:0]        line_out
);

  logic [LINE_W-1:0] hold_q, hold_d;
  logic [LINE_W-1:0] line_q, line_d;

  always_comb begin
    hold_d = hold_q;
    line_d = line_q;
    if (wr_en) begin
      hold_d[BEAT_W*wr_idx +: BEAT_W] = wr_beat;
    end
    if (commit) begin
      line_d = hold_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      line_q <= '0;
    end else begin
      hold_q <= hold_d;
      line_q <= line_d;
    end
  end

  assign line_out = line_q;

endmodule

// File: rtl/mem_beat_serializer.sv
// Splits 256-bit line reads/writes into four 64-bit back-end beats and reassembles reads.
// Write: 6 cycles capture-to-ready with ddr_cmd_ready=1; beats stall while ddr_cmd_ready=0.
module mem_beat_serializer
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int BEATS  = BEATS_PER_LINE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] mem_data_wr1,
  output logic [LINE_W-1:0] mem_data_rd1,
  input  logic [ADDR_W-1:0] mem_data_addr1,
  input  logic              mem_rw_data1,
  input  logic              mem_valid_data1,
  output logic              mem_ready_data1,
  output logic              ddr_cmd_valid,
  input  logic              ddr_cmd_ready,
  output logic              ddr_cmd_rw,
  output logic [ADDR_W-1:0] ddr_cmd_addr,
  output logic [BEAT_W-1:0] ddr_wdata,
  input  logic [BEAT_W-1:0] ddr_rdata,
  input  logic              ddr_rdata_valid,
  output logic              unaligned_seen
);

  localparam int IDX_W = $clog2(BEATS);
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] RET_FULL  = CNT_W'(BEATS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              rw_q, rw_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [IDX_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic              unal_q, unal_d;

  logic issuing;
  logic collect;
  logic commit;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    rw_d    = rw_q;
    line_d  = line_q;
    beat_d  = beat_q;
    ret_d   = ret_q;
    unal_d  = unal_q;

    issuing = (state_q == ST_WR_BEAT) || (state_q == ST_RD_CMD);
    // Returns can overlap issue, so collection runs in every busy state.
    collect = ddr_rdata_valid && (state_q != ST_IDLE) && (state_q != ST_DONE)
              && (ret_q != RET_FULL);
    if (collect) begin
      ret_d = ret_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (mem_valid_data1) begin
          base_d  = {mem_data_addr1[ADDR_W-1:3], 3'b000};
          rw_d    = mem_rw_data1;
          line_d  = mem_data_wr1;
          beat_d  = '0;
          ret_d   = '0;
          unal_d  = unal_q | (mem_data_addr1[2:0] != 3'b000);
          state_d = mem_rw_data1 ? ST_WR_BEAT : ST_RD_CMD;
        end
      end
      ST_WR_BEAT, ST_RD_CMD: begin
        if (ddr_cmd_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = rw_q ? ST_DONE : ST_RD_WAIT;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_RD_WAIT: begin
        if (ret_q == RET_FULL) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Publish the read line on entry to DONE so it is valid alongside the ready pulse.
    commit = (state_q == ST_RD_WAIT) && (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      rw_q    <= 1'b0;
      line_q  <= '0;
      beat_q  <= '0;
      ret_q   <= '0;
      unal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rw_q    <= rw_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      ret_q   <= ret_d;
      unal_q  <= unal_d;
    end
  end

  line_assembler #(.BEATS(BEATS)) u_line_assembler (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (collect),
    .wr_idx   (ret_q[IDX_W-1:0]),
    .wr_beat  (ddr_rdata),
    .commit   (commit),
    .line_out (mem_data_rd1)
  );

  assign mem_ready_data1 = (state_q == ST_DONE);
  assign ddr_cmd_valid   = issuing;
  assign ddr_cmd_rw      = rw_q;
  assign ddr_cmd_addr    = base_q + ADDR_W'(beat_q) * ADDR_W'(WORDS_PER_BEAT);
  assign ddr_wdata       = line_q[BEAT_W*beat_q +: BEAT_W];
  assign unaligned_seen  = unal_q;

endmodule

// File: tb/tb_mem_beat_serializer.sv
// Directed bench for mem_beat_serializer with a beat scoreboard and a 3-cycle read-return model.
module tb_mem_beat_serializer;

  logic         clk;
  logic         rst;
  logic [255:0] mem_data_wr1;
  logic [255:0] mem_data_rd1;
  logic [27:0]  mem_data_addr1;
  logic         mem_rw_data1;
  logic         mem_valid_data1;
  logic         mem_ready_data1;
  logic         ddr_cmd_valid;
  logic         ddr_cmd_ready;
  logic         ddr_cmd_rw;
  logic [27:0]  ddr_cmd_addr;
  logic [63:0]  ddr_wdata;
  logic [63:0]  ddr_rdata;
  logic         ddr_rdata_valid;
  logic         unaligned_seen;

  mem_beat_serializer dut (
    .clk             (clk),
    .rst             (rst),
    .mem_data_wr1    (mem_data_wr1),
    .mem_data_rd1    (mem_data_rd1),
    .mem_data_addr1  (mem_data_addr1),
    .mem_rw_data1    (mem_rw_data1),
    .mem_valid_data1 (mem_valid_data1),
    .mem_ready_data1 (mem_ready_data1),
    .ddr_cmd_valid   (ddr_cmd_valid),
    .ddr_cmd_ready   (ddr_cmd_ready),
    .ddr_cmd_rw      (ddr_cmd_rw),
    .ddr_cmd_addr    (ddr_cmd_addr),
    .ddr_wdata       (ddr_wdata),
    .ddr_rdata       (ddr_rdata),
    .ddr_rdata_valid (ddr_rdata_valid),
    .unaligned_seen  (unaligned_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [27:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdat;
  } beat_t;

  typedef struct packed {
    int          due;
    logic [63:0] data;
  } ret_t;

  beat_t       sb[$];
  ret_t        rq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          beats_in_cmd = 0;
  int          ready_seen = 0;
  int          stall_left = 0;
  bit          bp_arm = 0;
  bit          stalled_once = 0;
  bit          stall_fresh = 0;
  logic [27:0] snap_addr;
  logic [63:0] snap_wdata;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs just before each rising edge: drives ddr_cmd_ready / returns and scores accepted beats.
  task automatic monitor();
    beat_t e;
    ret_t  r;
    if (bp_arm && !stalled_once && ddr_cmd_valid && beats_in_cmd == 2) begin
      stall_left   = 5;
      stalled_once = 1;
      stall_fresh  = 1;
      snap_addr    = ddr_cmd_addr;
      snap_wdata   = ddr_wdata;
    end
    if (stall_left > 0) begin
      ddr_cmd_ready = 1'b0;
      stall_left--;
      if (!stall_fresh) begin
        chk("bp_valid_hold", ddr_cmd_valid, 1);
        chk("bp_addr_hold", ddr_cmd_addr, snap_addr);
        chk("bp_wdata_hold", ddr_wdata, snap_wdata);
      end
      stall_fresh = 0;
    end else begin
      ddr_cmd_ready = 1'b1;
    end
    if (ddr_cmd_valid && ddr_cmd_ready) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat_rw", ddr_cmd_rw, e.rw);
        chk("beat_addr", ddr_cmd_addr, e.addr);
        if (e.rw) chk("beat_wdata", ddr_wdata, e.wdata);
        else begin
          r.due  = cyc + 3;
          r.data = e.rdat;
          rq.push_back(r);
        end
      end
      beats_in_cmd++;
    end
    ddr_rdata_valid = 1'b0;
    ddr_rdata       = '0;
    if (rq.size() != 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      ddr_rdata_valid = 1'b1;
      ddr_rdata       = r.data;
    end
    if (mem_ready_data1) ready_seen++;
    cyc++;
  endtask

  task automatic tick();
    monitor();
    @(negedge clk);
  endtask

  task automatic push_cmd(input logic rw, input logic [27:0] addr, input logic [255:0] data);
    beat_t e;
    logic [27:0] base;
    base = addr & ~28'h7;
    for (int i = 0; i < 4; i++) begin
      e.rw    = rw;
      e.addr  = base + 28'(2 * i);
      e.wdata = data[64*i +: 64];
      e.rdat  = 64'h1111111111111111 * 64'(i + 1);
      sb.push_back(e);
    end
  endtask

  // Presents a command in IDLE; the tick here is the capture cycle (cycle 1).
  task automatic issue(input logic rw, input logic [27:0] addr, input logic [255:0] data,
                       input bit hold);
    mem_valid_data1 = 1'b1;
    mem_rw_data1    = rw;
    mem_data_addr1  = addr;
    mem_data_wr1    = data;
    push_cmd(rw, addr, data);
    beats_in_cmd = 0;
    tick();
    if (!hold) begin
      mem_valid_data1 = 1'b0;
      mem_data_wr1    = '1;
      mem_data_addr1  = 28'h5A5A5A7;
      mem_rw_data1    = ~rw;
    end
  endtask

  // Returns the cycle number (capture cycle = 1) at which mem_ready_data1 is seen.
  task automatic wait_ready(input string tag, input int max, output int n);
    n = 2;
    while (!mem_ready_data1 && n < max) begin
      tick();
      n++;
    end
    chk(tag, mem_ready_data1, 1);
  endtask

  logic [255:0] wr_line;
  logic [255:0] exp_rd;
  int           n;
  int           rdy_before;

  initial begin
    rst             = 1'b1;
    mem_data_wr1    = '0;
    mem_data_addr1  = '0;
    mem_rw_data1    = 1'b0;
    mem_valid_data1 = 1'b0;
    ddr_cmd_ready   = 1'b1;
    ddr_rdata       = '0;
    ddr_rdata_valid = 1'b0;
    for (int b = 0; b < 32; b++) wr_line[8*b +: 8] = 8'(b);
    exp_rd = {64'h4444444444444444, 64'h3333333333333333,
              64'h2222222222222222, 64'h1111111111111111};

    @(negedge clk);
    chk("rst_ready", mem_ready_data1, 0);
    chk("rst_cmd_valid", ddr_cmd_valid, 0);
    chk("rst_cmd_addr", ddr_cmd_addr, 0);
    chk("rst_wdata", ddr_wdata, 0);
    chk("rst_rd1", mem_data_rd1, 0);
    chk("rst_unaligned", unaligned_seen, 0);
    rst = 1'b0;
    tick();

    // Aligned write with ddr_cmd_ready always high.
    issue(1'b1, 28'h0C00000, wr_line, 0);
    chk("wr_beat0_wdata", ddr_wdata, 64'h0706050403020100);
    wait_ready("wr_ready", 40, n);
    chk("wr_latency", n, 6);
    tick();
    chk("wr_ready_one_cycle", mem_ready_data1, 0);

    // Read with 3-cycle return latency.
    rdy_before = ready_seen;
    issue(1'b0, 28'h0000008, {4{64'hDEADBEEFCAFEF00D}}, 0);
    wait_ready("rd_ready", 40, n);
    chk("rd_line", mem_data_rd1, exp_rd);
    tick();
    chk("rd_ready_one_cycle", mem_ready_data1, 0);
    chk("rd_single_pulse", ready_seen - rdy_before, 1);
    chk("aligned_no_flag", unaligned_seen, 0);

    // Back-pressure on beat 2.
    bp_arm = 1;
    issue(1'b1, 28'h0001000, ~wr_line, 0);
    wait_ready("bp_ready", 60, n);
    chk("bp_latency", n, 11);
    tick();
    bp_arm = 0;
    chk("bp_no_dup", sb.size(), 0);
    chk("rd_line_hold", mem_data_rd1, exp_rd);

    // Unaligned address at the top of the address space.
    issue(1'b1, 28'hFFFFFFD, {wr_line[127:0], wr_line[255:128]}, 0);
    chk("wrap_beat0_addr", ddr_cmd_addr, 28'hFFFFFF8);
    wait_ready("wrap_ready", 40, n);
    tick();
    chk("wrap_unaligned", unaligned_seen, 1);

    // Asynchronous reset after read beat 1 has been accepted.
    rdy_before = ready_seen;
    issue(1'b0, 28'h0000100, '0, 0);
    n = 0;
    while (beats_in_cmd < 2 && n < 30) begin
      tick();
      n++;
    end
    chk("rst_mid_reach", beats_in_cmd, 2);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ready", mem_ready_data1, 0);
    chk("rst_mid_valid", ddr_cmd_valid, 0);
    chk("rst_mid_rw", ddr_cmd_rw, 0);
    chk("rst_mid_addr", ddr_cmd_addr, 0);
    chk("rst_mid_wdata", ddr_wdata, 0);
    chk("rst_mid_rd1", mem_data_rd1, 0);
    chk("rst_mid_unaligned", unaligned_seen, 0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    issue(1'b1, 28'h0200040, wr_line ^ {8{32'h5A5A5A5A}}, 0);
    wait_ready("post_rst_ready", 40, n);
    chk("post_rst_latency", n, 6);
    tick();
    chk("rst_no_extra_pulse", ready_seen - rdy_before, 1);
    chk("post_rst_sb_empty", sb.size(), 0);

    // Three back-to-back writes with valid held high.
    rdy_before = ready_seen;
    push_cmd(1'b1, 28'h0000040, wr_line);
    push_cmd(1'b1, 28'h0000040, wr_line);
    issue(1'b1, 28'h0000040, wr_line, 1);
    for (int k = 0; k < 3; k++) begin
      wait_ready("b2b_ready", 40, n);
      if (k == 2) mem_valid_data1 = 1'b0;
      tick();
      chk("b2b_idle_no_cmd", ddr_cmd_valid, 0);
      chk("b2b_idle_no_ready", mem_ready_data1, 0);
      tick();
      chk("b2b_next_cmd", ddr_cmd_valid, (k < 2) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_pulses", ready_seen - rdy_before, 3);
    chk("b2b_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_beat_serializer.md
MEM_BEAT_SERIALIZER -- requirements
Module: mem_beat_serializer

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, meaning width of the word address on both sides.
REQ-002 SHALL have parameter BEATS, default 4, meaning the number of 64-bit beats per 256-bit line (fixed: 256/64).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port mem_data_wr1, input, 256, line write data from the cache-side master.
REQ-006 SHALL have port mem_data_rd1, output, 256, assembled line read data to the master.
REQ-007 SHALL have port mem_data_addr1, input, ADDR_W, line address in 32-bit word units.
REQ-008 SHALL have port mem_rw_data1, input, 1, command type: 1 = write, 0 = read.
REQ-009 SHALL have port mem_valid_data1, input, 1, master command valid.
REQ-010 SHALL have port mem_ready_data1, output, 1, one-cycle pulse when the line command completes.
REQ-011 SHALL have port ddr_cmd_valid, output, 1, back-end beat command valid.
REQ-012 SHALL have port ddr_cmd_ready, input, 1, back-end accepts the beat command this cycle.
REQ-013 SHALL have port ddr_cmd_rw, output, 1, beat type: 1 = write, 0 = read.
REQ-014 SHALL have port ddr_cmd_addr, output, ADDR_W, beat word address.
REQ-015 SHALL have port ddr_wdata, output, 64, beat write data.
REQ-016 SHALL have port ddr_rdata, input, 64, returned read beat.
REQ-017 SHALL have port ddr_rdata_valid, input, 1, ddr_rdata valid this cycle; returns arrive in issue order.
REQ-018 SHALL have port unaligned_seen, output, 1, sticky flag set when a command has mem_data_addr1[2:0] != 0.

Function
REQ-019 SHALL implement the states IDLE, WR_BEAT, RD_CMD, RD_WAIT and DONE.
REQ-020 In IDLE with mem_valid_data1=1, the block SHALL capture the address (with [2:0] forced to 0), rw and write data, clear the beat counters, and go to WR_BEAT if rw=1, else to RD_CMD.
REQ-021 Capturing a command with a nonzero addr[2:0] SHALL set unaligned_seen; the flag SHALL clear only on reset.
REQ-022 Beat i (0..3) SHALL use ddr_cmd_addr = base + 2*i and carry write data line[64*i+63:64*i]; beat 0 is the LSB beat.
REQ-023 In WR_BEAT and RD_CMD, ddr_cmd_valid SHALL be 1, and addr, rw and wdata SHALL be held stable until ddr_cmd_ready=1.
REQ-024 The beat index SHALL advance only on a cycle where ddr_cmd_valid and ddr_cmd_ready are both 1.
REQ-025 After write beat 3 is accepted, the block SHALL go to DONE.
REQ-026 After read beat 3 is accepted, the block SHALL go to RD_WAIT.
REQ-027 Read returns SHALL be collected in every state other than IDLE and DONE, including RD_CMD, so returns overlapping issue are not lost.
REQ-028 Return k SHALL write line slice [64*k+63:64*k] of a holding register, using a return counter independent of the issue counter.
REQ-029 The block SHALL go from RD_WAIT to DONE in the cycle after the 4th return is collected.
REQ-030 In DONE, mem_ready_data1 SHALL be 1 for exactly one cycle, followed by an unconditional return to IDLE.
REQ-031 Because of the DONE-to-IDLE transition, the minimum spacing between two accepted commands SHALL be one idle cycle.
REQ-032 mem_data_rd1 SHALL be updated only at DONE of a read, and SHALL hold that value until the next read completes.
REQ-033 Minimum latency from capture to mem_ready_data1 SHALL be 6 cycles for a write when ddr_cmd_ready is tied 1.
REQ-034 The master's inputs SHALL be ignored outside IDLE; mem_valid_data1 dropping mid-command SHALL NOT abort the command.
REQ-035 ddr_rdata_valid in IDLE or DONE SHALL be ignored.
REQ-036 Beat address arithmetic SHALL be modulo 2^ADDR_W; wrap-around is permitted.

Reset
REQ-037 When rst=1, the block SHALL asynchronously force state=IDLE, mem_ready_data1=0, ddr_cmd_valid=0, ddr_cmd_rw=0, ddr_cmd_addr=0, ddr_wdata=0, mem_data_rd1=0, unaligned_seen=0 and all counters to 0.
REQ-038 Reset mid-command SHALL discard the command with no mem_ready_data1 pulse; returns still in flight after reset SHALL be ignored.

Structure
REQ-039 Constants LINE_W=256, BEAT_W=64, the BEATS_PER_LINE value, the state encoding and WORDS_PER_BEAT=2 SHALL reside in a shared package, mem_if_pkg.
REQ-040 The design SHALL be a single module; the read assembly register MAY be split into a sub-module, line_assembler.

Verification
REQ-041 Write test: addr 0x0C00000, data = bytes 0x00..0x1F, ddr_cmd_ready=1 -> four beats at 0x0C00000/02/04/06 with wdata 0x0706050403020100 first, then mem_ready_data1 pulse at cycle 6.
REQ-042 Read test: addr 0x0000008, back-end returning 0x11..,0x22..,0x33..,0x44.. with 3-cycle latency -> mem_data_rd1 = {0x44..,0x33..,0x22..,0x11..} and a single ready pulse.
REQ-043 Back-pressure test: ddr_cmd_ready low 5 cycles on beat 2 -> beat 2 addr/data stable throughout, no duplicate beat.
REQ-044 Wrap and unaligned test: addr 0xFFFFFFD -> beats at 0xFFFFFF8, 0xFFFFFFA, 0xFFFFFFC, 0xFFFFFFE and unaligned_seen=1.
REQ-045 Reset test: rst asserted after read beat 1 issued -> all outputs zero immediately, and a subsequent write completes normally.
REQ-046 Back-to-back test: master holding valid across 3 line writes -> exactly 3 ready pulses, each followed by one IDLE cycle.
